// File: rtl/fp_norm_pipe.sv
// Two-stage post-addition normalizer: stage 1 finds the leading one, stage 2 shifts,
// adjusts the biased exponent and classifies the result as zero/subnormal/overflow.
module fp_norm_pipe #(
  parameter int MANT_W = 28,
  parameter int EXP_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_sign,
  input  logic [MANT_W-1:0] i_mant,
  input  logic [EXP_W-1:0]  i_exp,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_sign,
  output logic [MANT_W-1:0] o_mant,
  output logic [EXP_W-1:0]  o_exp,
  output logic              o_zero,
  output logic              o_subnormal,
  output logic              o_overflow
);

  localparam int POS_W = $clog2(MANT_W - 1);
  localparam int XW    = EXP_W + 1;

  logic              s1_valid_q, s1_valid_d;
  logic              s1_sign_q, s1_sign_d;
  logic [MANT_W-1:0] s1_mant_q, s1_mant_d;
  logic [EXP_W-1:0]  s1_exp_q, s1_exp_d;
  logic              s1_zero_q, s1_zero_d;
  logic              s1_carry_q, s1_carry_d;
  logic [POS_W-1:0]  s1_pos_q, s1_pos_d;

  logic              s2_valid_q, s2_valid_d;
  logic              s2_sign_q, s2_sign_d;
  logic [MANT_W-1:0] s2_mant_q, s2_mant_d;
  logic [EXP_W-1:0]  s2_exp_q, s2_exp_d;
  logic              s2_zero_q, s2_zero_d;
  logic              s2_sub_q, s2_sub_d;
  logic              s2_ovf_q, s2_ovf_d;

  logic              s2_load, s1_load, in_fire;
  logic [POS_W-1:0]  lod_pos;
  logic [POS_W-1:0]  shift_amt;
  logic [XW-1:0]     exp_x, shift_x, exp_inc, exp_dec;
  logic [EXP_W-1:0]  sub_shift;

  assign s2_load = ~s2_valid_q | i_ready;
  assign s1_load = ~s1_valid_q | s2_load;
  assign o_ready = s1_load;
  assign in_fire = i_valid & s1_load;

  // Leading-one position over the non-carry bits; the highest set bit wins.
  always_comb begin
    lod_pos = '0;
    for (int i = 0; i < MANT_W - 1; i++) begin
      if (i_mant[i]) lod_pos = POS_W'(i);
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_mant_d  = s1_mant_q;
    s1_exp_d   = s1_exp_q;
    s1_zero_d  = s1_zero_q;
    s1_carry_d = s1_carry_q;
    s1_pos_d   = s1_pos_q;
    if (s1_load) s1_valid_d = i_valid;
    if (in_fire) begin
      s1_sign_d  = i_sign;
      s1_mant_d  = i_mant;
      s1_exp_d   = i_exp;
      s1_zero_d  = (i_mant == '0);
      s1_carry_d = i_mant[MANT_W-1];
      s1_pos_d   = lod_pos;
    end
  end

  assign shift_amt = POS_W'(MANT_W - 2) - s1_pos_q;
  assign shift_x   = XW'(shift_amt);
  assign exp_x     = XW'(s1_exp_q);
  assign exp_inc   = exp_x + XW'(1);
  assign exp_dec   = exp_x - shift_x;
  assign sub_shift = s1_exp_q - EXP_W'(1);

  // Classification in priority order: zero, carry-out, exponent-limited, normal.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_mant_d  = s2_mant_q;
    s2_exp_d   = s2_exp_q;
    s2_zero_d  = s2_zero_q;
    s2_sub_d   = s2_sub_q;
    s2_ovf_d   = s2_ovf_q;
    if (s2_load) s2_valid_d = s1_valid_q;
    if (s2_load && s1_valid_q) begin
      s2_sign_d = s1_sign_q;
      s2_zero_d = 1'b0;
      s2_sub_d  = 1'b0;
      s2_ovf_d  = 1'b0;
      if (s1_zero_q) begin
        s2_mant_d = '0;
        s2_exp_d  = '0;
        s2_zero_d = 1'b1;
      end else if (s1_carry_q) begin
        s2_exp_d = exp_inc[EXP_W-1:0];
        if (exp_inc[EXP_W-1:0] == {EXP_W{1'b1}}) begin
          s2_mant_d = '0;
          s2_ovf_d  = 1'b1;
        end else begin
          s2_mant_d = {1'b0, s1_mant_q[MANT_W-1:2], s1_mant_q[1] | s1_mant_q[0]};
        end
      end else if (shift_x >= exp_x) begin
        s2_mant_d = s1_mant_q << sub_shift;
        s2_exp_d  = '0;
        s2_sub_d  = 1'b1;
      end else begin
        s2_mant_d = s1_mant_q << shift_amt;
        s2_exp_d  = exp_dec[EXP_W-1:0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mant_q  <= '0;
      s1_exp_q   <= '0;
      s1_zero_q  <= 1'b0;
      s1_carry_q <= 1'b0;
      s1_pos_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_mant_q  <= '0;
      s2_exp_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_sub_q   <= 1'b0;
      s2_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_mant_q  <= s1_mant_d;
      s1_exp_q   <= s1_exp_d;
      s1_zero_q  <= s1_zero_d;
      s1_carry_q <= s1_carry_d;
      s1_pos_q   <= s1_pos_d;
      s2_valid_q <= s2_valid_d;
      s2_sign_q  <= s2_sign_d;
      s2_mant_q  <= s2_mant_d;
      s2_exp_q   <= s2_exp_d;
      s2_zero_q  <= s2_zero_d;
      s2_sub_q   <= s2_sub_d;
      s2_ovf_q   <= s2_ovf_d;
    end
  end

  assign o_valid     = s2_valid_q;
  assign o_sign      = s2_sign_q;
  assign o_mant      = s2_mant_q;
  assign o_exp       = s2_exp_q;
  assign o_zero      = s2_zero_q;
  assign o_subnormal = s2_sub_q;
  assign o_overflow  = s2_ovf_q;

endmodule
